// File: rtl/mem_copier.sv
// Word-copy DMA engine: alternates granted read and write cycles on a shared
// data-memory port, copying len words from src to dst in ascending order.
module mem_copier #(
  parameter int unsigned MAX_LEN = 32
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] src,
  input  logic [31:0] dst,
  input  logic [5:0]  len,
  input  logic        grant,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 6;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q,   state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [AW-1:0] data_q,    data_d;
  logic [LW-1:0] rem_q,     rem_d;
  logic          err_q,     err_d;
  logic          start_ok;

  // A request is accepted only with word-aligned addresses and 1..MAX_LEN words
  assign start_ok = (src[1:0] == 2'b00) && (dst[1:0] == 2'b00) &&
                    (len != '0) && (AW'(len) <= AW'(MAX_LEN));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      data_q    <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_ptr_q <= src_ptr_d;
      dst_ptr_q <= dst_ptr_d;
      data_q    <= data_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
    end
  end

  // Next state; an ungranted READ/WRITE cycle is a stall and changes nothing
  always_comb begin
    state_d   = state_q;
    src_ptr_d = src_ptr_q;
    dst_ptr_d = dst_ptr_q;
    data_d    = data_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (start_ok) begin
            state_d   = S_READ;
            src_ptr_d = src;
            dst_ptr_d = dst;
            rem_d     = len;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        if (grant) begin
          data_d    = mem_rdata;
          src_ptr_d = src_ptr_q + AW'(4);
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        if (grant) begin
          dst_ptr_d = dst_ptr_q + AW'(4);
          rem_d     = rem_q - LW'(1);
          state_d   = (rem_q == LW'(1)) ? S_DONE : S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Port drive is all-zero outside READ/WRITE so it can be OR-muxed with the CPU
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_READ: mem_addr = src_ptr_q;
      S_WRITE: begin
        mem_addr  = dst_ptr_q;
        mem_wdata = data_q;
        mem_we    = grant;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_mem_copier.sv
// Randomized bench for mem_copier: a transfer-level model predicts every port
// each cycle, with hand-computed checks on the directed scenarios.
module tb_mem_copier;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [5:0]  len;
  logic        grant;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        err;

  logic [31:0] mem [64];
  logic [31:0] init_mem [64];
  logic        load_req;

  int n_checks;
  int n_fail;

  // Model of the transfer in progress: k counts granted accesses so far
  bit          m_active;
  bit          m_done;
  bit          m_err;
  logic [31:0] m_src;
  logic [31:0] m_dst;
  logic [31:0] m_data;
  int          m_len;
  int          m_k;

  mem_copier #(.MAX_LEN(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .grant     (grant),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr[7:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every cycle on the falling edge, then advance model and memory
  always @(negedge clock) begin
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_we;
    bit          nxt_done;
    bit          nxt_err;
    if (load_req) begin
      for (int i = 0; i < 64; i++) mem[i] = init_mem[i];
    end
    if (!resetn) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      m_active = 1'b0;
      m_done   = 1'b0;
      m_err    = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(m_active || m_done));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      e_addr  = 32'd0;
      e_we    = 1'b0;
      e_wdata = 32'd0;
      if (m_active) begin
        if (m_k % 2 == 0) begin
          e_addr = m_src + 32'(4 * (m_k / 2));
        end else begin
          e_addr  = m_dst + 32'(4 * (m_k / 2));
          e_we    = grant;
          e_wdata = m_data;
          chk("wdata", mem_wdata, e_wdata);
        end
      end else begin
        chk("idle_wdata", mem_wdata, 32'd0);
      end
      chk("addr", mem_addr, e_addr);
      chk("we", 32'(mem_we), 32'(e_we));
      nxt_done = 1'b0;
      nxt_err  = 1'b0;
      if (m_active && grant) begin
        if (m_k % 2 == 0) m_data = mem[e_addr[7:2]];
        m_k++;
        if (m_k == 2 * m_len) begin
          m_active = 1'b0;
          nxt_done = 1'b1;
        end
      end else if (!m_active && !m_done && start) begin
        if (src[1:0] != 2'b00 || dst[1:0] != 2'b00 || len == 6'd0 || len > 6'd32) begin
          nxt_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_k      = 0;
          m_len    = int'(len);
          m_src    = src;
          m_dst    = dst;
        end
      end
      m_done = nxt_done;
      m_err  = nxt_err;
    end
    if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
  end

  task automatic load_mem();
    load_req = 1'b1;
    @(negedge clock);
    #1;
    load_req = 1'b0;
  endtask

  // gmode: 0 = grant always, 1 = toggling 1,0,..., 2 = random
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int l,
                          input int gmode, input bit noise, input bit no_wait,
                          output int cyc, output int ng);
    if (!no_wait) begin
      @(posedge clock);
      #1;
    end
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = 6'(l);
    grant = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc   = 1;
    ng    = 0;
    while (!done && cyc < 400) begin
      case (gmode)
        0:       grant = 1'b1;
        1:       grant = (cyc % 2 == 1);
        default: grant = 1'($urandom_range(0, 1));
      endcase
      if (noise && cyc >= 2 && cyc <= 4) begin
        start = 1'b1;
        src   = 32'h3;
        len   = 6'd0;
      end else begin
        start = 1'b0;
      end
      if (grant && busy) ng++;
      @(posedge clock);
      #1;
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    grant = 1'b0;
    start = 1'b0;
  endtask

  task automatic err_case(input string name, input logic [31:0] s, input logic [31:0] d,
                          input logic [5:0] l);
    int ec;
    int wc;
    int bc;
    @(posedge clock);
    #1;
    start = 1'b1;
    src   = s;
    dst   = d;
    len   = l;
    grant = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    ec = 0;
    wc = 0;
    bc = 0;
    repeat (4) begin
      if (err) ec++;
      if (mem_we) wc++;
      if (busy) bc++;
      @(posedge clock);
      #1;
    end
    chk({name, "_errpulses"}, 32'(ec), 32'd1);
    chk({name, "_writes"}, 32'(wc), 32'd0);
    chk({name, "_busy"}, 32'(bc), 32'd0);
    grant = 1'b0;
  endtask

  initial begin
    int          cyc;
    int          ng;
    logic [31:0] saved [64];
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    grant    = 1'b0;
    src      = '0;
    dst      = '0;
    len      = '0;
    load_req = 1'b0;
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_k      = 0;
    m_len    = 0;
    m_src    = '0;
    m_dst    = '0;
    m_data   = '0;

    for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
    init_mem[0] = 32'h11;
    init_mem[1] = 32'h22;
    init_mem[2] = 32'h33;
    init_mem[3] = 32'h44;
    for (int i = 16; i < 20; i++) init_mem[i] = 32'h0;
    @(posedge clock);
    #1;
    load_mem();
    @(posedge clock);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_we", 32'(mem_we), 32'd0);
    chk("reset_addr", mem_addr, 32'd0);

    // Basic copy, start presented on the first edge after reset release
    resetn = 1'b1;
    run_xfer(32'h0, 32'h40, 4, 0, 1'b0, 1'b1, cyc, ng);
    chk("basic_latency", 32'(cyc), 32'd9);
    chk("basic_granted", 32'(ng), 32'd8);
    chk("basic_w0", mem[16], 32'h11);
    chk("basic_w1", mem[17], 32'h22);
    chk("basic_w2", mem[18], 32'h33);
    chk("basic_w3", mem[19], 32'h44);
    @(posedge clock);
    #1;
    chk("basic_busy_after", 32'(busy), 32'd0);

    // Stall with alternating grant, plus a start issued while busy
    init_mem = mem;
    for (int i = 16; i < 20; i++) init_mem[i] = 32'h0;
    load_mem();
    run_xfer(32'h0, 32'h40, 4, 1, 1'b1, 1'b0, cyc, ng);
    chk("stall_granted", 32'(ng), 32'd8);
    chk("stall_latency", 32'(cyc), 32'd16);
    chk("stall_w0", mem[16], 32'h11);
    chk("stall_w3", mem[19], 32'h44);

    err_case("err_src", 32'h2, 32'h40, 6'd1);
    err_case("err_len0", 32'h0, 32'h40, 6'd0);
    err_case("err_len33", 32'h0, 32'h40, 6'd33);
    err_case("err_dst", 32'h0, 32'h41, 6'd4);

    // Full-length copy from RAM into the IO space
    init_mem = mem;
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
    for (int i = 32; i < 64; i++) init_mem[i] = 32'h0;
    saved = init_mem;
    load_mem();
    run_xfer(32'h0, 32'h80, 32, 0, 1'b0, 1'b0, cyc, ng);
    chk("boundary_latency", 32'(cyc), 32'd65);
    for (int i = 0; i < 32; i++) chk("boundary_word", mem[32 + i], saved[i]);

    // Reset during the write of word 2 of 4
    init_mem = mem;
    init_mem[0] = 32'h11;
    init_mem[1] = 32'h22;
    init_mem[2] = 32'h33;
    init_mem[3] = 32'h44;
    for (int i = 48; i < 52; i++) init_mem[i] = 32'h0;
    load_mem();
    @(posedge clock);
    #1;
    start = 1'b1;
    src   = 32'h0;
    dst   = 32'hC0;
    len   = 6'd4;
    grant = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("pre_rst_we", 32'(mem_we), 32'd1);
    resetn = 1'b0;
    #1;
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (3) begin
      chk("rst_mid_nodone", 32'(done), 32'd0);
      @(posedge clock);
      #1;
    end
    chk("rst_mid_w0", mem[48], 32'h11);
    chk("rst_mid_w1", mem[49], 32'h0);
    grant = 1'b0;

    // Pointer wrap past 0xFFFFFFFC
    run_xfer(32'hFFFF_FFF8, 32'h20, 4, 2, 1'b0, 1'b0, cyc, ng);
    chk("wrap_granted", 32'(ng), 32'd8);

    // Random transfers and rejects; the compare process checks every port
    for (int t = 0; t < 50; t++) begin
      logic [31:0] rs;
      logic [31:0] rd;
      int          rl;
      rs = $urandom & 32'hFFFF_FFFC;
      rd = $urandom & 32'hFFFF_FFFC;
      rl = int'($urandom_range(1, 32));
      case ($urandom_range(0, 7))
        0:       err_case("rnd_err", rs | 32'(1 + $urandom_range(0, 2)), rd, 6'(rl));
        1:       err_case("rnd_len", rs, rd, 6'($urandom_range(33, 63)));
        default: begin
          run_xfer(rs, rd, rl, int'($urandom_range(0, 2)), (rl >= 2), 1'b0, cyc, ng);
          chk("rnd_granted", 32'(ng), 32'(2 * rl));
        end
      endcase
    end

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copier.md
MEM_COPIER -- requirements
Module: mem_copier

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, giving the maximum words per transfer; this matches the 32-word data RAM.
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a transfer; sampled only in IDLE.
REQ-005 SHALL have port src, input, 32 bits: source byte address of the first word.
REQ-006 SHALL have port dst, input, 32 bits: destination byte address of the first word.
REQ-007 SHALL have port len, input, 6 bits: number of words to copy.
REQ-008 SHALL have port grant, input, 1 bit: the CPU memory stage yields the data-memory port this cycle.
REQ-009 SHALL have port mem_rdata, input, 32 bits: memory read data, valid within the same cycle as mem_addr.
REQ-010 SHALL have port mem_we, output, 1 bit: write enable, held for the whole cycle; the memory qualifies it with the low clock phase.
REQ-011 SHALL have port mem_addr, output, 32 bits: byte address; bit 7 selects the IO space, bits 6:2 select the word.
REQ-012 SHALL have port mem_wdata, output, 32 bits: write data.
REQ-013 SHALL have port busy, output, 1 bit: high from the accepted start until DONE is left.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.

Function
REQ-016 SHALL implement the states IDLE, READ, WRITE and DONE.
REQ-017 IDLE with start=1 SHALL perform these checks, with err as a one-cycle pulse and no memory access:
- src[1:0]!=0, dst[1:0]!=0, len==0 or len>MAX_LEN: err=1, stay in IDLE.
- Otherwise: latch src_ptr=src, dst_ptr=dst, remaining=len, then go to READ.
REQ-018 READ with grant=1 SHALL:
- drive mem_addr=src_ptr, mem_we=0;
- capture mem_rdata into buf at the clock edge;
- set src_ptr+=4;
- go to WRITE.
REQ-019 WRITE with grant=1 SHALL:
- drive mem_addr=dst_ptr, mem_we=1, mem_wdata=buf;
- set dst_ptr+=4 and remaining-=1;
- go to DONE if remaining was 1, else go to READ.
REQ-020 With grant=0 in READ or WRITE, the block SHALL hold its state, pointers and buf, and drive mem_we=0; the cycle is a stall, not an access.
REQ-021 A transfer SHALL take 2*len granted cycles; latency from start to done = 2*len + 1 cycles with grant held at 1.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; busy=0 in the following IDLE cycle.
REQ-023 Pointer arithmetic SHALL be 32-bit modulo 2^32; wrap past 0xFFFFFFFC to 0x0 is legal and unflagged.
REQ-024 start while busy=1 SHALL be ignored, with no err, and the in-flight transfer SHALL be unaffected.
REQ-025 When not in WRITE with grant=1, the block SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 outside READ and WRITE, so that it contributes nothing on a shared port mux.
REQ-026 Ranges crossing bit 7 (RAM to IO or IO to RAM) SHALL be legal; the addresses are passed through unmodified.
REQ-027 Overlapping src and dst ranges SHALL be copied in ascending word order, with no overlap detection.

Reset
REQ-028 resetn=0 SHALL, asynchronously, force state=IDLE and clear src_ptr, dst_ptr, remaining and buf to 0.
REQ-029 resetn=0 SHALL, asynchronously, force busy, done, err and mem_we to 0.
REQ-030 Reset asserted mid-transfer SHALL abort it immediately, with no done and no further write; words already written remain in memory.
REQ-031 After resetn deasserts, the first start SHALL be accepted on the first rising edge.

Verification
REQ-032 Basic copy: RAM words 0..3 = 0x11,0x22,0x33,0x44; start with src=0x0, dst=0x40, len=4, grant=1 -> addresses 0x0,0x40,0x4,0x44,... alternate reads and writes; done pulse on cycle 9; RAM 0x40..0x4C = 0x11..0x44.
REQ-033 Stall: same transfer with grant toggling 1,0,1,0 -> mem_we=0 on every grant=0 cycle; final memory as in REQ-032; done after 8 granted cycles.
REQ-034 Errors -> err pulses once, busy stays 0, and no mem_we occurs for each of:
- src=0x2 with len=1;
- dst=0x40 with len=0;
- len=33.
REQ-035 Boundary: src=0x0, dst=0x80, len=32 -> 32 writes to the IO space 0x80..0xFC; done after 65 cycles; the final dst_ptr is 0x100.
REQ-036 Reset and ignored start:
- resetn pulsed low during WRITE of word 2 of 4 -> mem_we drops in the same cycle, no done, and the destination holds only word 1.
- start asserted while busy -> ignored.
